// File: rtl/instr_pkg.sv
// Shared constants and state encoding for the instruction bundler.
package instr_pkg;

  localparam int INSTR_W    = 32;
  localparam int BUNDLE_MAX = 6;
  localparam int QTY_W      = 4;
  localparam int BUNDLE_W   = 192;
  localparam int MEM_DEPTH  = 1024;
  localparam int TOTAL_W    = 11;
  localparam logic [INSTR_W-1:0] NOP_WORD = 32'h0000_0013;

  typedef enum logic {
    FILL = 1'b0,
    EMIT = 1'b1
  } bundler_state_t;

endpackage

// File: rtl/instruction_bundler.sv
// Packs a valid/ready stream of 32-bit instructions into 2..6 word bundles and
// issues each as a one-cycle registered write pulse, tracking memory capacity.
module instruction_bundler
  import instr_pkg::*;
#(
  parameter int MAX_BUNDLE = instr_pkg::BUNDLE_MAX,
  parameter int MEM_DEPTH  = instr_pkg::MEM_DEPTH,
  parameter logic [31:0] NOP_WORD = instr_pkg::NOP_WORD
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  input  logic [INSTR_W-1:0]  in_instr,
  input  logic                in_last,
  input  logic                flush,
  output logic                in_ready,
  output logic                write_enable,
  output logic [BUNDLE_W-1:0] instructions,
  output logic [QTY_W-1:0]    quantity,
  output logic                mem_full,
  output logic [TOTAL_W-1:0]  words_total
);

  bundler_state_t state_reg, state_next;
  logic [2:0] count_reg, count_next;
  logic [BUNDLE_MAX-1:0][INSTR_W-1:0] lane_reg, lane_next;
  logic we_reg, we_next;
  logic [BUNDLE_W-1:0] instr_reg, instr_next;
  logic [QTY_W-1:0] qty_reg, qty_next;
  logic [TOTAL_W-1:0] total_reg, total_next;
  logic full_reg, full_next;

  logic accept;
  logic close;
  logic [QTY_W-1:0] post_count;
  logic [TOTAL_W-1:0] rem;
  logic [TOTAL_W-1:0] total_upd;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= FILL;
      count_reg <= '0;
      lane_reg  <= '0;
      we_reg    <= 1'b0;
      instr_reg <= '0;
      qty_reg   <= '0;
      total_reg <= '0;
      full_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
      lane_reg  <= lane_next;
      we_reg    <= we_next;
      instr_reg <= instr_next;
      qty_reg   <= qty_next;
      total_reg <= total_next;
      full_reg  <= full_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    lane_next  = lane_reg;
    we_next    = 1'b0;
    instr_next = '0;
    qty_next   = '0;
    total_next = total_reg;
    full_next  = full_reg;
    accept     = 1'b0;
    close      = 1'b0;
    post_count = {1'b0, count_reg};
    rem        = TOTAL_W'(MEM_DEPTH) - total_reg;
    total_upd  = total_reg + TOTAL_W'(qty_reg);
    in_ready   = (state_reg == FILL) && !full_reg;

    case (state_reg)
      FILL: begin
        accept     = in_valid && !full_reg;
        post_count = {1'b0, count_reg} + QTY_W'(accept);
        if (accept) begin
          lane_next[count_reg] = in_instr;
        end
        // A bare flush only closes a non-empty bundle.
        if (accept) begin
          close = (post_count == QTY_W'(MAX_BUNDLE)) || in_last || flush ||
                  (TOTAL_W'(post_count) == rem);
        end else begin
          close = flush && (count_reg != 3'd0);
        end
        count_next = post_count[2:0];
        if (close) begin
          state_next = EMIT;
          we_next    = 1'b1;
          instr_next = lane_next;
          qty_next   = post_count;
          if (post_count == QTY_W'(1)) begin
            instr_next[2*INSTR_W-1:INSTR_W] = NOP_WORD;
            qty_next = QTY_W'(2);
          end
        end
      end
      EMIT: begin
        state_next = FILL;
        count_next = '0;
        lane_next  = '0;
        total_next = total_upd;
        // One leftover slot can never hold a legal bundle, so stop below two.
        full_next  = (TOTAL_W'(MEM_DEPTH) - total_upd) < TOTAL_W'(2);
      end
      default: begin
        state_next = FILL;
      end
    endcase
  end

  assign write_enable = we_reg;
  assign instructions = instr_reg;
  assign quantity     = qty_reg;
  assign mem_full     = full_reg;
  assign words_total  = total_reg;

endmodule

// File: tb/tb_instruction_bundler.sv
// Self-checking bench: vector table plus scoreboard of expected bundle pulses.
module tb_instruction_bundler;
  import instr_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic in_valid;
  logic [31:0] in_instr;
  logic in_last;
  logic flush;
  logic in_ready;
  logic write_enable;
  logic [191:0] instructions;
  logic [3:0] quantity;
  logic mem_full;
  logic [10:0] words_total;

  instruction_bundler dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_instr(in_instr),
    .in_last(in_last), .flush(flush), .in_ready(in_ready),
    .write_enable(write_enable), .instructions(instructions),
    .quantity(quantity), .mem_full(mem_full), .words_total(words_total)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [191:0] instr;
    logic [3:0]   qty;
    int           cyc;
  } exp_t;

  typedef struct {
    logic        valid;
    logic [31:0] instr;
    logic        last;
    logic        flush;
    int          exp_qty;
  } vec_t;

  exp_t sb[$];
  vec_t tbl[$];
  logic [31:0] pend[$];
  int checks = 0;
  int fails = 0;
  int model_total = 0;

  task automatic check(input string name, input logic [191:0] act, input logic [191:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic push_expected(input int q, input int c);
    exp_t e;
    e.instr = '0;
    for (int k = 0; k < pend.size(); k++) e.instr[k*32 +: 32] = pend[k];
    if (pend.size() == 1) e.instr[63:32] = NOP_WORD;
    e.qty = 4'(q);
    e.cyc = c;
    sb.push_back(e);
    model_total += q;
    pend.delete();
  endtask

  task automatic apply_vec(input vec_t v);
    bit ok;
    if (v.valid || v.flush) begin
      in_valid = v.valid; in_instr = v.instr; in_last = v.last; flush = v.flush;
      ok = 1'b0;
      for (int i = 0; i < 50; i++) begin
        @(negedge clk);
        if (in_ready) begin ok = 1'b1; break; end
        @(posedge clk); #1;
      end
      if (!ok) begin
        checks++; fails++;
        $display("FAIL accept_timeout: got in_ready 0 for 50 cycles, required 1");
      end else begin
        if (v.valid) pend.push_back(v.instr);
        if (v.exp_qty != 0) push_expected(v.exp_qty, cyc + 1);
      end
      @(posedge clk); #1;
      in_valid = 1'b0; in_last = 1'b0; flush = 1'b0; in_instr = '0;
      if (ok && v.exp_qty != 0) begin
        @(posedge clk); #1;
        check("words_total", 192'(words_total), 192'(model_total));
      end
    end else begin
      in_last = v.last;
      @(posedge clk); #1;
      in_last = 1'b0;
    end
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    repeat (n) @(posedge clk);
    #1 rst = 1'b0;
    pend.delete();
    model_total = 0;
    check("rst_write_enable", 192'(write_enable), 192'(0));
    check("rst_quantity", 192'(quantity), 192'(0));
    check("rst_instructions", instructions, 192'(0));
    check("rst_mem_full", 192'(mem_full), 192'(0));
    check("rst_words_total", 192'(words_total), 192'(0));
    check("rst_in_ready", 192'(in_ready), 192'(1));
  endtask

  function automatic vec_t mk(input logic valid, input logic [31:0] instr,
                              input logic last, input logic fl, input int q);
    vec_t v;
    v.valid = valid; v.instr = instr; v.last = last; v.flush = fl; v.exp_qty = q;
    return v;
  endfunction

  // Scoreboard consumer: every pulse must match the oldest expected bundle.
  initial begin
    exp_t e;
    bit prev_we;
    prev_we = 1'b0;
    forever begin
      @(negedge clk);
      if (write_enable) begin
        if (sb.size() == 0) begin
          checks++; fails++;
          $display("FAIL unexpected_pulse: got quantity %0d, required no pulse", quantity);
        end else begin
          e = sb.pop_front();
          $display("bundle: cycle %0d quantity %0d instructions %0h", cyc, quantity, instructions);
          check("pulse_quantity", 192'(quantity), 192'(e.qty));
          check("pulse_instructions", instructions, e.instr);
          check("pulse_cycle", 192'(cyc), 192'(e.cyc));
          check("ready_in_emit", 192'(in_ready), 192'(0));
        end
      end else if (prev_we) begin
        check("quantity_cleared", 192'(quantity), 192'(0));
        check("instructions_cleared", instructions, 192'(0));
      end
      prev_we = write_enable;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "bench timeout");
  end

  initial begin
    int seen;
    rst = 1'b1; in_valid = 1'b0; in_instr = '0; in_last = 1'b0; flush = 1'b0;

    for (int k = 1; k <= 6; k++) tbl.push_back(mk(1'b1, 32'(k * 'h11), 1'b0, 1'b0, (k == 6) ? 6 : 0));
    tbl.push_back(mk(1'b1, 32'hA1, 1'b0, 1'b0, 0));
    tbl.push_back(mk(1'b1, 32'hA2, 1'b0, 1'b0, 0));
    tbl.push_back(mk(1'b1, 32'hA3, 1'b1, 1'b0, 3));
    tbl.push_back(mk(1'b1, 32'hBEEF, 1'b0, 1'b0, 0));
    tbl.push_back(mk(1'b0, 32'h0, 1'b0, 1'b1, 2));
    tbl.push_back(mk(1'b0, 32'h0, 1'b0, 1'b1, 0));
    tbl.push_back(mk(1'b0, 32'h0, 1'b1, 1'b0, 0));
    tbl.push_back(mk(1'b1, 32'hC1, 1'b1, 1'b1, 2));

    do_reset(3);
    for (int i = 0; i < tbl.size(); i++) apply_vec(tbl[i]);

    // Idle with stray flush / in_last: no pulse may appear.
    tbl.delete();
    tbl.push_back(mk(1'b0, 32'h0, 1'b0, 1'b1, 0));
    tbl.push_back(mk(1'b0, 32'h0, 1'b1, 1'b0, 0));
    for (int i = 0; i < tbl.size(); i++) apply_vec(tbl[i]);
    repeat (10) @(posedge clk);
    #1;
    check("idle_words_total", 192'(words_total), 192'(model_total));
    check("idle_scoreboard_empty", 192'(sb.size()), 192'(0));

    // Reset with four words buffered discards them.
    for (int k = 0; k < 4; k++) apply_vec(mk(1'b1, 32'hD0 + 32'(k), 1'b0, 1'b0, 0));
    do_reset(1);
    repeat (3) @(posedge clk);
    #1;
    apply_vec(mk(1'b1, 32'hE1, 1'b0, 1'b0, 0));
    apply_vec(mk(1'b1, 32'hE2, 1'b1, 1'b0, 2));

    // Capacity boundary: 170 full bundles then a remainder-limited close.
    do_reset(1);
    for (int b = 0; b < 170; b++)
      for (int w = 0; w < 6; w++)
        apply_vec(mk(1'b1, {16'(b), 16'(w)}, 1'b0, 1'b0, (w == 5) ? 6 : 0));
    check("pre_full_total", 192'(words_total), 192'(1020));
    check("pre_full_flag", 192'(mem_full), 192'(0));
    for (int w = 0; w < 4; w++)
      apply_vec(mk(1'b1, 32'hF000 + 32'(w), 1'b0, 1'b0, (w == 3) ? 4 : 0));
    check("full_total", 192'(words_total), 192'(1024));
    check("full_flag", 192'(mem_full), 192'(1));

    in_valid = 1'b1; in_instr = 32'hF004;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (in_ready) seen++;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("full_never_ready", 192'(seen), 192'(0));
    check("full_total_held", 192'(words_total), 192'(1024));
    check("final_scoreboard_empty", 192'(sb.size()), 192'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
